// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the voice allocator.
//   - FSM state encoding (IDLE, SCAN, APPLY, RETRIG) as plain localparams
//   - RANKBITS for the default voice count
//   - note_evt_t: captured note event {on, num, phase}
// Optional feature macro used by the allocator: VOICE_ALLOCATOR_SUSTAIN_EN.
package voice_alloc_pkg;

    localparam int unsigned NVoicesDflt   = 4;
    localparam int unsigned NoteBitsDflt  = 7;
    localparam int unsigned PhaseSizeDflt = 16;
    localparam int unsigned RANKBITS      = $clog2(NVoicesDflt);

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StScan   = 2'd1;
    localparam state_t StApply  = 2'd2;
    localparam state_t StRetrig = 2'd3;

    // Field widths track the default NOTEBITS / PHASESIZE of the allocator.
    typedef struct packed {
        logic                     on;
        logic [NoteBitsDflt-1:0]  num;
        logic [PhaseSizeDflt-1:0] phase;
    } note_evt_t;

endpackage

// File: rtl/voice_select.sv
// Combinational voice search used in the SCAN cycle.
// Ports:
//   active_i       per-voice "holds a note" flags
//   note_i         per-voice stored note number
//   rank_i         per-voice allocation age (0 = newest, NVOICES-1 = oldest)
//   num_i          note number being searched for
//   match_valid_o  / match_idx_o   lowest active voice holding num_i
//   free_valid_o   / free_idx_o    lowest inactive voice
//   oldest_idx_o                   voice whose rank is NVOICES-1
module voice_select
    import voice_alloc_pkg::*;
#(
    parameter int unsigned NVOICES  = 4,
    parameter int unsigned NOTEBITS = 7,
    parameter int unsigned RankW    = 2
) (
    input  logic [NVOICES-1:0]               active_i,
    input  logic [NVOICES-1:0][NOTEBITS-1:0] note_i,
    input  logic [NVOICES-1:0][RankW-1:0]    rank_i,
    input  logic [NOTEBITS-1:0]              num_i,
    output logic                             match_valid_o,
    output logic [RankW-1:0]                 match_idx_o,
    output logic                             free_valid_o,
    output logic [RankW-1:0]                 free_idx_o,
    output logic [RankW-1:0]                 oldest_idx_o
);

    // Walk from the top down so the lowest qualifying index wins.
    always_comb begin
        match_valid_o = 1'b0;
        match_idx_o   = '0;
        free_valid_o  = 1'b0;
        free_idx_o    = '0;
        oldest_idx_o  = '0;
        for (int i = int'(NVOICES) - 1; i >= 0; i--) begin
            if (active_i[i] && (note_i[i] == num_i)) begin
                match_valid_o = 1'b1;
                match_idx_o   = RankW'(i);
            end
            if (!active_i[i]) begin
                free_valid_o = 1'b1;
                free_idx_o   = RankW'(i);
            end
            if (rank_i[i] == RankW'(NVOICES - 1)) begin
                oldest_idx_o = RankW'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: assigns note-on/off events to NVOICES voices and
// drives per-voice phase increments and envelope gates.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   sustain_i           sustain pedal (only with VOICE_ALLOCATOR_SUSTAIN_EN)
//   note_valid_i/ready  event handshake; ready only while idle
//   note_on_i, note_num_i, note_phase_i   event fields
//   freq_flat_o         voice i at [32*i +: 32], zero-extended phase word
//   gate_o              envelope gate per voice
//   active_mask_o       voice holds a sounding note
//   steal_pulse_o       one-cycle pulse when the oldest voice is stolen
// Optional feature macro: VOICE_ALLOCATOR_SUSTAIN_EN (sustain pedal support).
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int unsigned NVOICES       = NVoicesDflt,
    parameter int unsigned PHASESIZE     = PhaseSizeDflt,
    parameter int unsigned NOTEBITS      = NoteBitsDflt,
    parameter int unsigned RETRIG_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    input  logic                  sustain_i,
`endif
    input  logic                  note_valid_i,
    output logic                  note_ready_o,
    input  logic                  note_on_i,
    input  logic [NOTEBITS-1:0]   note_num_i,
    input  logic [PHASESIZE-1:0]  note_phase_i,
    output logic [NVOICES*32-1:0] freq_flat_o,
    output logic [NVOICES-1:0]    gate_o,
    output logic [NVOICES-1:0]    active_mask_o,
    output logic                  steal_pulse_o
);

    localparam int unsigned RankW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam int unsigned CntW  = $clog2(RETRIG_CYCLES + 1);

    state_t                               state_q, state_d;
    note_evt_t                            evt_q, evt_d;
    logic [NVOICES-1:0][PHASESIZE-1:0]    freq_q, freq_d;
    logic [NVOICES-1:0][NOTEBITS-1:0]     note_q, note_d;
    logic [NVOICES-1:0][RankW-1:0]        rank_q, rank_d;
    logic [NVOICES-1:0]                   active_q, active_d;
    logic [NVOICES-1:0]                   gate_q, gate_d;
    logic                                 match_v_q, match_v_d;
    logic [RankW-1:0]                     match_q, match_d;
    logic                                 free_v_q, free_v_d;
    logic [RankW-1:0]                     free_q, free_d;
    logic [RankW-1:0]                     oldest_q, oldest_d;
    logic [RankW-1:0]                     tgt_q, tgt_d;
    logic [CntW-1:0]                      cnt_q, cnt_d;
    logic                                 steal_q, steal_d;
    logic [RankW-1:0]                     tgt;

    logic                                 sel_match_v, sel_free_v;
    logic [RankW-1:0]                     sel_match, sel_free, sel_oldest;

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    logic [NVOICES-1:0]                   sus_q, sus_d;
    logic                                 sus_prev_q;
    logic                                 pending_q, pending_d;
    logic                                 pedal_fall;

    assign pedal_fall   = sus_prev_q & ~sustain_i;
    assign note_ready_o = (state_q == StIdle) & ~pending_q;
`else
    assign note_ready_o = (state_q == StIdle);
`endif

    voice_select #(
        .NVOICES  (NVOICES),
        .NOTEBITS (NOTEBITS),
        .RankW    (RankW)
    ) u_select (
        .active_i      (active_q),
        .note_i        (note_q),
        .rank_i        (rank_q),
        .num_i         (evt_q.num),
        .match_valid_o (sel_match_v),
        .match_idx_o   (sel_match),
        .free_valid_o  (sel_free_v),
        .free_idx_o    (sel_free),
        .oldest_idx_o  (sel_oldest)
    );

    always_comb begin
        state_d   = state_q;
        evt_d     = evt_q;
        freq_d    = freq_q;
        note_d    = note_q;
        rank_d    = rank_q;
        active_d  = active_q;
        gate_d    = gate_q;
        match_v_d = match_v_q;
        match_d   = match_q;
        free_v_d  = free_v_q;
        free_d    = free_q;
        oldest_d  = oldest_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        steal_d   = 1'b0;
        tgt       = tgt_q;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        sus_d     = sus_q;
        pending_d = pending_q | pedal_fall;
`endif
        case (state_q)
            StIdle: begin
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                // Pedal release wins over a new event in the same cycle.
                if (pending_q) begin
                    gate_d    = gate_q & ~sus_q;
                    active_d  = active_q & ~sus_q;
                    sus_d     = '0;
                    pending_d = pedal_fall;
                end else
`endif
                if (note_valid_i) begin
                    evt_d.on    = note_on_i;
                    evt_d.num   = note_num_i;
                    evt_d.phase = note_phase_i;
                    state_d     = StScan;
                end
            end
            StScan: begin
                match_v_d = sel_match_v;
                match_d   = sel_match;
                free_v_d  = sel_free_v;
                free_d    = sel_free;
                oldest_d  = sel_oldest;
                state_d   = StApply;
            end
            StApply: begin
                state_d = StIdle;
                if (evt_q.on) begin
                    if (match_v_q) begin
                        tgt = match_q;
                    end else if (free_v_q) begin
                        tgt = free_q;
                    end else begin
                        tgt = oldest_q;
                    end
                    tgt_d          = tgt;
                    freq_d[tgt]    = evt_q.phase;
                    note_d[tgt]    = evt_q.num;
                    active_d[tgt]  = 1'b1;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                    sus_d[tgt]     = 1'b0;
`endif
                    // Voices younger than the target age by one; target becomes newest.
                    for (int i = 0; i < int'(NVOICES); i++) begin
                        if (rank_q[i] < rank_q[tgt]) begin
                            rank_d[i] = rank_q[i] + RankW'(1);
                        end
                    end
                    rank_d[tgt] = '0;
                    if (gate_q[tgt]) begin
                        gate_d[tgt] = 1'b0;
                        cnt_d       = CntW'(RETRIG_CYCLES);
                        state_d     = StRetrig;
                        steal_d     = ~match_v_q & ~free_v_q;
                    end else begin
                        gate_d[tgt] = 1'b1;
                    end
                end else if (match_v_q) begin
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                    if (sustain_i) begin
                        sus_d[match_q] = 1'b1;
                    end else begin
                        gate_d[match_q]   = 1'b0;
                        active_d[match_q] = 1'b0;
                        sus_d[match_q]    = 1'b0;
                    end
`else
                    // freq is left alone so the release tail keeps its pitch.
                    gate_d[match_q]   = 1'b0;
                    active_d[match_q] = 1'b0;
`endif
                end
            end
            StRetrig: begin
                // Count of 1 here means this edge is the last low cycle.
                if (cnt_q <= CntW'(1)) begin
                    gate_d[tgt_q] = 1'b1;
                    cnt_d         = '0;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            evt_q     <= '0;
            freq_q    <= '0;
            note_q    <= '0;
            active_q  <= '0;
            gate_q    <= '0;
            match_v_q <= 1'b0;
            match_q   <= '0;
            free_v_q  <= 1'b0;
            free_q    <= '0;
            oldest_q  <= '0;
            tgt_q     <= '0;
            cnt_q     <= '0;
            steal_q   <= 1'b0;
            for (int i = 0; i < int'(NVOICES); i++) begin
                rank_q[i] <= RankW'(int'(NVOICES) - 1 - i);
            end
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            sus_q      <= '0;
            sus_prev_q <= 1'b0;
            pending_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            evt_q     <= evt_d;
            freq_q    <= freq_d;
            note_q    <= note_d;
            rank_q    <= rank_d;
            active_q  <= active_d;
            gate_q    <= gate_d;
            match_v_q <= match_v_d;
            match_q   <= match_d;
            free_v_q  <= free_v_d;
            free_q    <= free_d;
            oldest_q  <= oldest_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            steal_q   <= steal_d;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            sus_q      <= sus_d;
            sus_prev_q <= sustain_i;
            pending_q  <= pending_d;
`endif
        end
    end

    always_comb begin
        freq_flat_o = '0;
        for (int i = 0; i < int'(NVOICES); i++) begin
            freq_flat_o[32*i +: PHASESIZE] = freq_q[i];
        end
    end

    assign gate_o        = gate_q;
    assign active_mask_o = active_q;
    assign steal_pulse_o = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus randomized
// events compared against a queue-based allocation model.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int R  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sustain = 1'b0;
    logic          note_valid = 1'b0;
    logic          note_ready;
    logic          note_on = 1'b0;
    logic [6:0]    note_num = '0;
    logic [15:0]   note_phase = '0;
    logic [NV*32-1:0] freq_flat;
    logic [NV-1:0] gate;
    logic [NV-1:0] active_mask;
    logic          steal_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: order holds voices newest-first, oldest at the back.
    bit          m_active[NV];
    bit          m_gate[NV];
    bit          m_sus[NV];
    int          m_note[NV];
    logic [15:0] m_freq[NV];
    int          order[$];
    bit          cur_sus = 1'b0;

    voice_allocator #(
        .NVOICES       (NV),
        .PHASESIZE     (16),
        .NOTEBITS      (7),
        .RETRIG_CYCLES (R)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        .sustain_i     (sustain),
`endif
        .note_valid_i  (note_valid),
        .note_ready_o  (note_ready),
        .note_on_i     (note_on),
        .note_num_i    (note_num),
        .note_phase_i  (note_phase),
        .freq_flat_o   (freq_flat),
        .gate_o        (gate),
        .active_mask_o (active_mask),
        .steal_pulse_o (steal_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NV-1:0] exp_gate();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_gate[i];
        return v;
    endfunction

    function automatic logic [NV-1:0] exp_active();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_active[i];
        return v;
    endfunction

    function automatic logic [NV*32-1:0] exp_freq();
        logic [NV*32-1:0] v;
        v = '0;
        for (int i = 0; i < NV; i++) v[32*i +: 16] = m_freq[i];
        return v;
    endfunction

    task automatic model_reset();
        order = {};
        for (int i = 0; i < NV; i++) begin
            m_active[i] = 0; m_gate[i] = 0; m_sus[i] = 0; m_note[i] = 0; m_freq[i] = '0;
            order.push_back(NV - 1 - i);
        end
    endtask

    task automatic model_apply(input bit on, input int num, input int phase, input bit sus,
                               output int tgt, output bit retrig, output bit steal);
        int match = -1;
        int free  = -1;
        for (int i = 0; i < NV; i++) begin
            if (m_active[i] && m_note[i] == num && match < 0) match = i;
            if (!m_active[i] && free < 0) free = i;
        end
        tgt = -1; retrig = 0; steal = 0;
        if (on) begin
            if (match >= 0) tgt = match;
            else if (free >= 0) tgt = free;
            else begin tgt = order[order.size()-1]; steal = 1; end
            retrig = m_gate[tgt];
            steal  = steal && retrig;
            m_freq[tgt] = 16'(phase); m_note[tgt] = num;
            m_active[tgt] = 1; m_sus[tgt] = 0; m_gate[tgt] = 1;
            for (int k = 0; k < order.size(); k++) begin
                if (order[k] == tgt) begin order.delete(k); break; end
            end
            order.push_front(tgt);
        end else if (match >= 0) begin
            tgt = match;
            if (sus) m_sus[match] = 1;
            else begin m_gate[match] = 0; m_active[match] = 0; m_sus[match] = 0; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; note_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One event with full cycle-accurate checking through the retrigger window.
    task automatic do_event(input bit on, input int num, input int phase);
        int n = 0;
        int tgt;
        bit rt, st;
        logic [NV-1:0] g;
        note_on = on; note_num = 7'(num); note_phase = 16'(phase);
        note_valid = 1'b1;
        while (!note_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!note_ready) begin
            check_val("handshake_timeout", 0, 1);
            note_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        note_valid = 1'b0;
        check_val("ready_low_scan", note_ready, 0);
        model_apply(on, num, phase, cur_sus, tgt, rt, st);
        @(posedge clk); #1;
        check_val("no_early_update", steal_pulse, 0);
        @(posedge clk); #1;
        g = exp_gate();
        if (rt) g[tgt] = 1'b0;
        check_val("apply_gate", gate, g);
        check_val("apply_active", active_mask, exp_active());
        check_val("apply_freq", freq_flat, exp_freq());
        check_val("apply_steal", steal_pulse, st);
        check_val("apply_ready", note_ready, !rt);
        if (rt) begin
            for (int k = 1; k < R; k++) begin
                @(posedge clk); #1;
                check_val("retrig_gate_low", gate, g);
                check_val("retrig_steal_clear", steal_pulse, 0);
                check_val("retrig_ready_low", note_ready, 0);
            end
            @(posedge clk); #1;
            check_val("retrig_gate_high", gate, exp_gate());
            check_val("retrig_ready_back", note_ready, 1);
        end
    endtask

    initial begin
        int ev_on[6];
        int ev_num[6];
        int ev_ph[6];
        int idx, cyc, pulses, exp_pulses, tgt, n;
        bit rt, st, rdy;

        model_reset();
        do_reset();
        check_val("rst_gate", gate, 0);
        check_val("rst_active", active_mask, 0);
        check_val("rst_freq", freq_flat, 0);
        check_val("rst_steal", steal_pulse, 0);
        check_val("rst_ready", note_ready, 1);

        // Single note-on.
        do_event(1, 60, 'h0444);
        check_val("t1_gate", gate, 4'b0001);
        check_val("t1_freq0", freq_flat[31:0], 32'h0000_0444);
        check_val("t1_active", active_mask, 4'b0001);

        // Fill all voices then steal the oldest.
        do_reset();
        do_event(1, 60, 'h100);
        do_event(1, 62, 'h200);
        do_event(1, 64, 'h300);
        do_event(1, 67, 'h400);
        do_event(1, 72, 'h555);
        check_val("steal_freq0", freq_flat[31:0], 32'h0000_0555);
        check_val("steal_freq1", freq_flat[63:32], 32'h0000_0200);

        // Same note twice retriggers voice 0 only.
        do_reset();
        do_event(1, 60, 'h111);
        do_event(1, 60, 'h222);
        check_val("retrig_active", active_mask, 4'b0001);
        check_val("retrig_freq0", freq_flat[31:0], 32'h0000_0222);

        // Note-off keeps freq; unmatched note-off changes nothing.
        do_reset();
        do_event(1, 60, 'h0444);
        do_event(0, 60, 0);
        check_val("off_gate", gate, 4'b0000);
        check_val("off_active", active_mask, 4'b0000);
        check_val("off_freq0", freq_flat[31:0], 32'h0000_0444);
        do_event(0, 61, 0);
        do_event(1, 0, 0);

        // note_valid held high across six events.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ev_on[i]  = ($urandom_range(0, 3) != 0);
            ev_num[i] = $urandom_range(0, 5);
            ev_ph[i]  = $urandom_range(0, 65535);
        end
        idx = 0; cyc = 0; pulses = 0; exp_pulses = 0;
        note_on = ev_on[0][0]; note_num = 7'(ev_num[0]); note_phase = 16'(ev_ph[0]);
        note_valid = 1'b1;
        while (idx < 6 && cyc < 300) begin
            rdy = note_ready;
            @(posedge clk); #1;
            cyc++;
            if (steal_pulse) pulses++;
            if (rdy) begin
                model_apply(ev_on[idx] != 0, ev_num[idx], ev_ph[idx], 0, tgt, rt, st);
                exp_pulses += int'(st);
                idx++;
                check_val("stream_ready_low", note_ready, 0);
                if (idx < 6) begin
                    note_on = ev_on[idx][0]; note_num = 7'(ev_num[idx]);
                    note_phase = 16'(ev_ph[idx]);
                end else begin
                    note_valid = 1'b0;
                end
            end
        end
        note_valid = 1'b0;
        check_val("stream_accepted", idx, 6);
        n = 0;
        while (!note_ready && n < 50) begin
            @(posedge clk); #1; n++;
            if (steal_pulse) pulses++;
        end
        check_val("stream_idle", note_ready, 1);
        check_val("stream_gate", gate, exp_gate());
        check_val("stream_active", active_mask, exp_active());
        check_val("stream_freq", freq_flat, exp_freq());
        check_val("stream_steals", pulses, exp_pulses);

        // Reset in the middle of a retrigger.
        do_reset();
        do_event(1, 60, 'h0444);
        note_on = 1'b1; note_num = 7'd60; note_phase = 16'h0999; note_valid = 1'b1;
        @(posedge clk); #1;
        note_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("mid_retrig_gate", gate, 4'b0000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_val("rst_retrig_gate", gate, 0);
        check_val("rst_retrig_active", active_mask, 0);
        check_val("rst_retrig_freq", freq_flat, 0);
        check_val("rst_retrig_ready", note_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        check_val("rst_retrig_stays", gate, 0);

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        // Pedal holds a released note until it is lifted.
        do_reset();
        sustain = 1'b1; cur_sus = 1'b1;
        do_event(1, 60, 'h0444);
        do_event(0, 60, 0);
        check_val("sus_gate_held", gate, 4'b0001);
        check_val("sus_active_held", active_mask, 4'b0001);
        sustain = 1'b0; cur_sus = 1'b0;
        @(posedge clk); #1;
        check_val("sus_pending_ready", note_ready, 0);
        @(posedge clk); #1;
        for (int i = 0; i < NV; i++) begin
            if (m_sus[i]) begin m_gate[i] = 0; m_active[i] = 0; m_sus[i] = 0; end
        end
        check_val("sus_release_gate", gate, 4'b0000);
        check_val("sus_release_active", active_mask, exp_active());
        check_val("sus_release_ready", note_ready, 1);
`endif

        // Randomized events over a small note range to force matches and steals.
        do_reset();
        for (int e = 0; e < 60; e++) begin
            do_event($urandom_range(0, 9) < 6, $urandom_range(0, 9),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
